shiftblock_driver: RTL and testbench
====================================

Name: shiftblock_driver

Overview:
- Avalon-MM master that drives the 16-tap shift-block coprocessor slave on the same fabric.
- Consumes a byte stream and pushes each byte into the coprocessor shift register.
- After the last byte, reads back the coprocessor's max-window-sum and window-valid registers and reports them to the requester.
- Sits between a software/DMA byte source and the coprocessor, replacing per-byte CPU writes.

Parameters:
- LEN_W, 16, width of the byte-count request.
- SETTLE, 2, idle cycles between the last shift write and the first readback; must be ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- length  in  LEN_W  number of bytes to stream; sampled with start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when result and window_full are updated
- result  out  32  max window sum read from slave word 8
- window_full  out  1  bit 0 of slave word 9
- in_data  in  8  stream byte
- in_valid  in  1  stream byte valid
- in_ready  out  1  block accepts byte this cycle
- avm_address  out  4  slave word address
- avm_read  out  1  read strobe
- avm_write  out  1  write strobe
- avm_writedata  out  32  write data
- avm_byteenable  out  4  byte lanes
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (async, active-high):
  - state = IDLE; busy, done, in_ready, avm_read, avm_write = 0.
  - avm_address = 0, avm_writedata = 0, avm_byteenable = 0.
  - result = 0, window_full = 0, byte counter = 0.
  - Reset mid-transfer aborts immediately with no further bus activity; the slave's contents are left as-is.
- Bus rule:
  - A transfer completes in a cycle where read or write is high and avm_waitrequest is low.
  - Address, data, byteenable and strobe are held stable while waitrequest is high.
  - readdata is captured in the completing cycle.
  - read and write are never high together.
- IDLE:
  - busy = 0.
  - On start: latch length into the counter, set busy, go to CLEAR.
  - start while busy is ignored.
- CLEAR:
  - Write address 1, writedata 0, byteenable F. This resets the slave's max accumulator.
  - On completion: go to GETBYTE if counter ≠ 0, else SETTLE.
- GETBYTE:
  - in_ready = 1 (the only state where it is high).
  - On in_valid & in_ready: capture in_data, go to SHIFT.
- SHIFT:
  - Write address 0, writedata = {24'h0, byte}, byteenable 4'h1. The exact byteenable 4'h1 is required by the slave for a shift.
  - On completion: decrement the counter; go to GETBYTE if the counter is now ≠ 0, else SETTLE.
- SETTLE:
  - Idle SETTLE cycles, then go to RDVALID.
  - Reason: the slave's taps update one cycle after the write and maxsum one cycle later.
- RDVALID:
  - Read address 9, byteenable F.
  - On completion: window_full ← readdata[0]; go to RDMAX.
- RDMAX:
  - Read address 8, byteenable F.
  - On completion: result ← readdata; go to DONE.
- DONE:
  - done = 1 for one cycle, busy drops the same cycle, go to IDLE.
- Throughput is a minimum of 2 cycles per byte with no waitrequest; stalls extend states without reordering.
- length = 0 still performs CLEAR, SETTLE, RDVALID, RDMAX; result is 0 on a freshly cleared slave.
- The counter is LEN_W bits with no wrap: the maximum length is 2^LEN_W − 1.
- result and window_full hold their values until the next done.

Test Plan:
- length=16, stream 16×0x01, waitrequest tied 0 → bus write sequence shows clear (addr 1) then 16 shift writes (addr 0, byteenable 1); done with result=16, window_full=1.
- length=20, bytes 0..19 → result=184 (sum 4..19), window_full=1; exactly 20 shift writes, exactly 2 reads.
- length=5, bytes 0xFF → window_full=0, result=0; done after RDMAX.
- length=0 → no shift writes, no in_ready; done with result=0.
- length=16 with random waitrequest (≈50%) and random in_valid gaps → result and write sequence identical to the stall-free run; strobes and data stable throughout every stall.
- Assert reset after 7 bytes, then run length=16 of 0x02 → outputs 0 immediately on reset; second run gives result=32.

Source files
------------

// File: rtl/shiftblock_driver.sv
// Avalon-MM master that streams bytes into the 16-tap shift-block coprocessor,
// then reads back its window-valid flag and max window sum.
module shiftblock_driver #(
  parameter int LEN_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic             window_full,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  output logic [3:0]       avm_byteenable,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_GETBYTE = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_SETTLE  = 3'd4;
  localparam logic [2:0] ST_RDVALID = 3'd5;
  localparam logic [2:0] ST_RDMAX   = 3'd6;
  localparam logic [2:0] ST_DONE    = 3'd7;

  localparam int SC_W = $clog2(SETTLE + 1);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic [SC_W-1:0]  settle_q, settle_d;
  logic [31:0]      result_q, result_d;
  logic             wfull_q, wfull_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;
  logic [3:0]       addr_q, addr_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             xfer_done;

  assign xfer_done = (rd_q | wr_q) & ~avm_waitrequest;

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    settle_d = settle_q;
    result_d = result_q;
    wfull_d  = wfull_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = length;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (xfer_done) begin
          settle_d = {SC_W{1'b0}};
          state_d  = (cnt_q != {LEN_W{1'b0}}) ? ST_GETBYTE : ST_SETTLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_GETBYTE: begin
        if (in_valid) begin
          byte_d  = in_data;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_GETBYTE;
        end
      end
      ST_SHIFT: begin
        if (xfer_done) begin
          cnt_d    = cnt_q - LEN_W'(1);
          settle_d = {SC_W{1'b0}};
          state_d  = (cnt_q != LEN_W'(1)) ? ST_GETBYTE : ST_SETTLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SETTLE: begin
        // Slave taps lag the write by one cycle and maxsum by one more.
        if (settle_q == SC_W'(SETTLE - 1)) begin
          state_d = ST_RDVALID;
        end else begin
          settle_d = settle_q + SC_W'(1);
        end
      end
      ST_RDVALID: begin
        if (xfer_done) begin
          wfull_d = avm_readdata[0];
          state_d = ST_RDMAX;
        end else begin
          state_d = ST_RDVALID;
        end
      end
      ST_RDMAX: begin
        if (xfer_done) begin
          result_d = avm_readdata;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_RDMAX;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register cleanly.
  always_comb begin
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    in_ready_d = (state_d == ST_GETBYTE);
    wr_d       = (state_d == ST_CLEAR) || (state_d == ST_SHIFT);
    rd_d       = (state_d == ST_RDVALID) || (state_d == ST_RDMAX);
    case (state_d)
      ST_CLEAR: begin
        addr_d  = 4'd1;
        wdata_d = 32'h0000_0000;
        be_d    = 4'hF;
      end
      ST_SHIFT: begin
        addr_d  = 4'd0;
        wdata_d = {24'h00_0000, byte_d};
        be_d    = 4'h1;
      end
      ST_RDVALID: begin
        addr_d  = 4'd9;
        wdata_d = 32'h0000_0000;
        be_d    = 4'hF;
      end
      ST_RDMAX: begin
        addr_d  = 4'd8;
        wdata_d = 32'h0000_0000;
        be_d    = 4'hF;
      end
      default: begin
        addr_d  = 4'd0;
        wdata_d = 32'h0000_0000;
        be_d    = 4'h0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {LEN_W{1'b0}};
      byte_q     <= 8'h00;
      settle_q   <= {SC_W{1'b0}};
      result_q   <= 32'h0000_0000;
      wfull_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
      addr_q     <= 4'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      be_q       <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      settle_q   <= settle_d;
      result_q   <= result_d;
      wfull_q    <= wfull_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign window_full    = wfull_q;
  assign in_ready       = in_ready_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;

endmodule

// File: tb/tb_shiftblock_driver.sv
// Scoreboard bench for shiftblock_driver with a behavioural 16-tap shift-block slave.
module tb_shiftblock_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] length;
  logic        busy, done, window_full, in_ready;
  logic [31:0] result;
  logic [7:0]  in_data;
  logic        in_valid;
  logic [3:0]  avm_address, avm_byteenable;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest = 1'b0;

  shiftblock_driver #(.LEN_W(16), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .busy(busy), .done(done), .result(result), .window_full(window_full),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  // Slave model: word 0 shifts a byte in, word 1 clears maxsum, maxsum tracks full windows.
  logic [7:0]  taps [16];
  int          scount;
  logic [31:0] maxsum;
  logic        pend;
  logic        slv_rst;
  logic        stall_en = 1'b0;

  function automatic logic [31:0] tap_sum();
    logic [31:0] s = 32'd0;
    for (int i = 0; i < 16; i++) s = s + {24'd0, taps[i]};
    return s;
  endfunction

  always @(posedge clk) begin
    if (slv_rst) begin
      for (int i = 0; i < 16; i++) taps[i] <= 8'h00;
      scount <= 0;
      maxsum <= 32'd0;
      pend   <= 1'b0;
    end else begin
      pend <= 1'b0;
      if (pend && scount >= 16 && tap_sum() > maxsum) maxsum <= tap_sum();
      if (avm_write && !avm_waitrequest) begin
        if (avm_address == 4'd1) maxsum <= 32'd0;
        else if (avm_address == 4'd0 && avm_byteenable == 4'h1) begin
          taps[0] <= avm_writedata[7:0];
          for (int i = 1; i < 16; i++) taps[i] <= taps[i-1];
          scount <= (scount < 16) ? scount + 1 : 16;
          pend   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (avm_address == 4'd8) avm_readdata = maxsum;
    else if (avm_address == 4'd9) avm_readdata = {31'd0, (scount >= 16)};
    else avm_readdata = 32'd0;
  end

  always @(posedge clk) avm_waitrequest <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;

  // Scoreboard state.
  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } bus_t;

  bus_t        exp_bus [$];
  logic [32:0] exp_res [$];
  logic [7:0]  stim [$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          tmo_req = 0, tmo_seen = 0;
  int          rst_req = 0, rst_seen = 0;
  logic        chk_bus = 1'b1;
  logic        no_inready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [41:0] snap;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    bus_t        e;
    logic [32:0] r;
    if (tmo_req != tmo_seen) begin
      chk("timeout", 64'(tmo_req), 64'(tmo_seen));
      tmo_seen = tmo_req;
    end
    if (rst_req != rst_seen) begin
      rst_seen = rst_req;
      chk("reset_outputs",
          {busy, done, in_ready, avm_read, avm_write, avm_address, avm_byteenable, window_full},
          64'd0);
      chk("reset_data", {result, avm_writedata}, 64'd0);
    end
    if (no_inready) chk("no_in_ready", 64'(in_ready), 64'd0);
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_stable", 64'({avm_read, avm_write, avm_address, avm_writedata, avm_byteenable}),
            64'(snap));
      if (avm_read || avm_write) chk("rw_exclusive", 64'(avm_read & avm_write), 64'd0);
      prev_stall = (avm_read || avm_write) && avm_waitrequest;
      snap = {avm_read, avm_write, avm_address, avm_writedata, avm_byteenable};
      if (chk_bus && (avm_read || avm_write) && !avm_waitrequest) begin
        if (exp_bus.size() == 0) begin
          chk("bus_extra", 64'({avm_write, avm_address}), 64'h1F);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_xfer",
              {23'd0, avm_write, avm_address, avm_write ? avm_writedata : 32'd0, avm_byteenable},
              {23'd0, e});
        end
      end
      if (done) begin
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("bus_pending", 64'(exp_bus.size()), 64'd0);
        if (exp_res.size() == 0) begin
          chk("done_extra", 64'(done), 64'd0);
        end else begin
          r = exp_res.pop_front();
          chk("result", 64'(result), 64'(r[31:0]));
          chk("window_full", 64'(window_full), 64'(r[32]));
        end
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) return;
    end
    tmo_req++;
  endtask

  task automatic feed(input int lo, input int hi, input bit gaps);
    int k;
    for (int i = lo; i < hi; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      in_data  = stim[i];
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 500) begin
        @(negedge clk);
        k++;
      end
      if (k >= 500) tmo_req++;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start(input int len);
    start  = 1'b1;
    length = 16'(len);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic run(input int len, input bit gaps, input int poke,
                     input logic [31:0] exp_r, input logic exp_wf);
    exp_bus.push_back({1'b1, 4'd1, 32'd0, 4'hF});
    for (int i = 0; i < len; i++) exp_bus.push_back({1'b1, 4'd0, 24'd0, stim[i], 4'h1});
    exp_bus.push_back({1'b0, 4'd9, 32'd0, 4'hF});
    exp_bus.push_back({1'b0, 4'd8, 32'd0, 4'hF});
    exp_res.push_back({exp_wf, exp_r});
    pulse_start(len);
    if (poke > 0) begin
      feed(0, poke, gaps);
      pulse_start(3);
      feed(poke, len, gaps);
    end else begin
      feed(0, len, gaps);
    end
    wait_done();
    repeat (2) @(negedge clk);
  endtask

  task automatic slave_reset();
    slv_rst = 1'b1;
    repeat (2) @(negedge clk);
    slv_rst = 1'b0;
  endtask

  initial begin
    reset = 1'b1; slv_rst = 1'b1; start = 1'b0; length = 16'd0;
    in_data = 8'h00; in_valid = 1'b0;
    #2 rst_req++;
    repeat (2) @(negedge clk);
    reset = 1'b0; slv_rst = 1'b0;
    @(negedge clk);

    // 16 x 0x01 into a fresh slave.
    stim = {};
    for (int i = 0; i < 16; i++) stim.push_back(8'h01);
    run(16, 1'b0, 0, 32'd16, 1'b1);

    // Bytes 0..19 with an ignored start mid-run; best window is 4..19.
    stim = {};
    for (int i = 0; i < 20; i++) stim.push_back(8'(i));
    run(20, 1'b0, 10, 32'd184, 1'b1);

    // Window never fills.
    slave_reset();
    stim = {};
    for (int i = 0; i < 5; i++) stim.push_back(8'hFF);
    run(5, 1'b0, 0, 32'd0, 1'b0);

    // Zero length: no byte may be taken even with data offered.
    no_inready = 1'b1;
    in_data = 8'hAA; in_valid = 1'b1;
    run(0, 1'b0, 0, 32'd0, 1'b0);
    in_valid = 1'b0; no_inready = 1'b0;

    // Random slave stalls and source gaps.
    slave_reset();
    stall_en = 1'b1;
    stim = {};
    for (int i = 0; i < 16; i++) stim.push_back(8'h01);
    run(16, 1'b1, 0, 32'd16, 1'b1);
    stall_en = 1'b0;
    repeat (2) @(negedge clk);

    // Abort after 7 bytes, then a clean run of 0x02.
    chk_bus = 1'b0;
    pulse_start(16);
    feed(0, 7, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    rst_req++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_bus = 1'b1;
    @(negedge clk);
    stim = {};
    for (int i = 0; i < 16; i++) stim.push_back(8'h02);
    run(16, 1'b0, 0, 32'd32, 1'b1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
